// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 encodings, sequencer state encoding and
// the per-op latency lookup used by the multiply/divide sequencer.
package rv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_CLASS_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  // Iteration count for an M-extension op; anything outside the multiply group is a divide/remainder.
  function automatic int mdLatency(input logic [2:0] funct3, input int mulCycles, input int divCycles);
    int lat;
    case (funct3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: lat = mulCycles;
      default:                              lat = divCycles;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter that times the iterative unit: loads L-1, counts down to zero
// and flags zero so the sequencer knows the final iteration is underway.
module md_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Clear (kill) wins over a new load; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadValue;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative RV32M unit in EX: holds the instruction in EX
// for the unit's latency and drives start/done/abort plus pipeline stalls.
module muldiv_seq_ctrl
  import rv_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mdvalidE,
  input  logic [2:0] funct3E,
  input  logic       divzeroE,
  input  logic       killE,
  input  logic       stall_ext,
  output logic       md_start,
  output logic       md_done,
  output logic       md_abort,
  output logic       md_busy,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushM
);

  mdState_t         state;
  mdState_t         stateNext;
  logic             isDiv;
  logic             divByZero;
  logic             startReq;
  logic             stallAll;
  logic             cntLoad;
  logic             cntDec;
  logic             cntClear;
  logic             cntZero;
  logic [CNT_W-1:0] cntLoadValue;

  assign isDiv        = funct3E[DIV_CLASS_BIT];
  assign divByZero    = isDiv && divzeroE;
  assign startReq     = (state == IDLE) && mdvalidE && !killE;
  assign cntLoadValue = CNT_W'(mdLatency(funct3E, MUL_CYCLES, DIV_CYCLES) - 1);

  // Divide-by-zero has an architecturally fixed result, so the counter is never loaded for it.
  assign cntLoad  = startReq && !divByZero;
  assign cntDec   = (state == BUSY) && !killE;
  assign cntClear = killE;

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) uLatCounter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cntClear),
    .load     (cntLoad),
    .loadValue(cntLoadValue),
    .dec      (cntDec),
    .zero     (cntZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A kill from trap/redirect always returns the sequencer to IDLE, whatever it was doing.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (startReq) begin
          stateNext = divByZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cntZero) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!stall_ext) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (killE) begin
      stateNext = IDLE;
    end
  end

  // Outputs are forced low during reset since IDLE decode alone would still react to mdvalidE.
  always_comb begin
    md_start = 1'b0;
    md_done  = 1'b0;
    md_abort = 1'b0;
    md_busy  = 1'b0;
    stallAll = 1'b0;
    if (!rst) begin
      md_busy  = (state != IDLE);
      md_abort = killE && (state != IDLE);
      unique case (state)
        IDLE: begin
          md_start = startReq;
          stallAll = startReq;
        end
        BUSY:    stallAll = !killE;
        DONE:    md_done  = !killE;
        default: stallAll = 1'b0;
      endcase
    end
  end

  assign stallF = stallAll;
  assign stallD = stallAll;
  assign stallE = stallAll;
  assign flushM = stallAll;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: per-cycle output vectors plus a
// scoreboard of expected md_done cycles pushed when each op is issued.
module tb_muldiv_seq_ctrl;
  import rv_pkg::*;

  localparam int MulCycles = 4;
  localparam int DivCycles = 32;
  localparam int CntW      = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       mdvalidE;
  logic [2:0] funct3E;
  logic       divzeroE;
  logic       killE;
  logic       stall_ext;
  logic       md_start, md_done, md_abort, md_busy;
  logic       stallF, stallD, stallE, flushM;

  int vectors     = 0;
  int miscompares = 0;
  int cycleNum    = 0;
  int prevStart   = -1;
  int lastStart   = -1;
  int expDoneQ[$];

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(
    .MUL_CYCLES(MulCycles),
    .DIV_CYCLES(DivCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mdvalidE (mdvalidE),
    .funct3E  (funct3E),
    .divzeroE (divzeroE),
    .killE    (killE),
    .stall_ext(stall_ext),
    .md_start (md_start),
    .md_done  (md_done),
    .md_abort (md_abort),
    .md_busy  (md_busy),
    .stallF   (stallF),
    .stallD   (stallD),
    .stallE   (stallE),
    .flushM   (flushM)
  );

  function automatic logic [7:0] expVec(input logic start, input logic done, input logic abort,
                                        input logic busy, input logic stall);
    return {start, done, abort, busy, stall, stall, stall, stall};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [2:0] f3, input logic dz,
                               input logic kill, input logic sx);
    @(posedge clk);
    #1;
    mdvalidE  = valid;
    funct3E   = f3;
    divzeroE  = dz;
    killE     = kill;
    stall_ext = sx;
    cycleNum++;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    @(negedge clk);
    observed = {md_start, md_done, md_abort, md_busy, stallF, stallD, stallE, flushM};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cycleNum, observed, expected);
    end
  endtask

  task automatic compareValue(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One M op from issue through its final DONE cycle; extCycles holds DONE via stall_ext.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic dz, input int extCycles);
    int  lat;
    int  doneAt;
    int  lastC;
    int  starts;
    int  expDone;
    bit  seenDone;
    lat      = f3[2] ? DivCycles : MulCycles;
    doneAt   = (f3[2] && dz) ? 1 : lat + 1;
    lastC    = doneAt + extCycles;
    starts   = 0;
    seenDone = 1'b0;
    for (int c = 0; c <= lastC; c++) begin
      applyStimulus(1'b1, f3, dz, 1'b0, (c >= doneAt) && (c < lastC));
      if (c == 0) expDoneQ.push_back(cycleNum + doneAt);
      checkOutput(tag, expVec(c == 0, c >= doneAt, 1'b0, c > 0, c < doneAt));
      if (md_start) begin
        starts++;
        prevStart = lastStart;
        lastStart = cycleNum;
      end
      if (md_done && !seenDone) begin
        seenDone = 1'b1;
        if (expDoneQ.size() == 0) begin
          compareValue({tag, " unexpected done"}, 1, 0);
        end else begin
          expDone = expDoneQ.pop_front();
          compareValue({tag, " done cycle"}, cycleNum, expDone);
        end
      end
    end
    if (!seenDone) begin
      compareValue({tag, " done timeout"}, 0, 1);
      if (expDoneQ.size() != 0) expDone = expDoneQ.pop_front();
    end
    compareValue({tag, " start count"}, starts, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] muldiv_seq_ctrl bench start");
    rst       = 1'b1;
    mdvalidE  = 1'b1;
    funct3E   = F3_MUL;
    divzeroE  = 1'b0;
    killE     = 1'b0;
    stall_ext = 1'b0;
    checkOutput("reset with mdvalidE high", expVec(0, 0, 0, 0, 0));

    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("idle after reset", expVec(0, 0, 0, 0, 0));

    runOp("mul", F3_MUL, 1'b0, 0);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("idle after mul", expVec(0, 0, 0, 0, 0));

    runOp("div", F3_DIV, 1'b0, 0);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("busy low after div", expVec(0, 0, 0, 0, 0));

    runOp("divu by zero", F3_DIVU, 1'b1, 0);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("idle after divu by zero", expVec(0, 0, 0, 0, 0));

    runOp("mulhu stall_ext at done", F3_MULHU, 1'b0, 3);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("idle after held done", expVec(0, 0, 0, 0, 0));

    runOp("mul b2b", F3_MUL, 1'b0, 0);
    runOp("rem b2b", F3_REM, 1'b0, 0);
    compareValue("b2b start gap", lastStart - prevStart, MulCycles + 2);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("idle after b2b", expVec(0, 0, 0, 0, 0));

    applyStimulus(1'b1, F3_MUL, 1'b0, 1'b1, 1'b0);
    checkOutput("kill in idle", expVec(0, 0, 0, 0, 0));

    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, F3_DIV, 1'b0, 1'b0, 1'b0);
      checkOutput("div before kill", expVec(c == 0, 0, 0, c > 0, 1));
    end
    applyStimulus(1'b1, F3_DIV, 1'b0, 1'b1, 1'b0);
    checkOutput("kill in busy", expVec(0, 0, 1, 1, 0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
      checkOutput("idle after kill", expVec(0, 0, 0, 0, 0));
    end

    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, F3_DIVU, 1'b0, 1'b0, 1'b0);
      checkOutput("divu before reset", expVec(c == 0, 0, 0, c > 0, 1));
    end
    applyStimulus(1'b1, F3_DIVU, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    checkOutput("reset mid-busy", expVec(0, 0, 0, 0, 0));
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("idle after reset release", expVec(0, 0, 0, 0, 0));
    runOp("mulh after reset", F3_MULH, 1'b0, 0);
    applyStimulus(1'b0, F3_MUL, 1'b0, 1'b0, 1'b0);
    checkOutput("final idle", expVec(0, 0, 0, 0, 0));

    compareValue("scoreboard drained", expDoneQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
